// File: rtl/fetch2_bundle_queue_if.sv
// fetch2_bundle_queue_if: bundle handshake between the Fetch1-Fetch2 register, the queue and Fetch2
//   flush_i         pipeline flush
//   laneActive_i    per-lane enable, used only for valid_bundle_o
//   fs1Ready_i      incoming bundle valid
//   fs2Packet_i     incoming packets, lane 0 in LSBs
//   predCounter_i   incoming 2-bit predictor counters, lane 0 in LSBs
//   stall_i         Fetch2 back-pressure, 1 = do not pop
//   stall_o         hold request to Fetch1 (queue full)
//   fs2Ready_o      head bundle valid
//   fs2Packet_o     head packets
//   predCounter_o   head predictor counters
//   valid_bundle_o  per-lane valid of the head bundle
//   occupancy_o     entries currently held
// master drives the inputs of the queue; slave is the queue itself.
interface fetch2_bundle_queue_if #(
    parameter int FETCH_WIDTH = 4,
    parameter int PKT_W       = 64,
    parameter int DEPTH       = 4
);
    logic                         flush_i;
    logic [FETCH_WIDTH-1:0]       laneActive_i;
    logic                         fs1Ready_i;
    logic [FETCH_WIDTH*PKT_W-1:0] fs2Packet_i;
    logic [FETCH_WIDTH*2-1:0]     predCounter_i;
    logic                         stall_i;
    logic                         stall_o;
    logic                         fs2Ready_o;
    logic [FETCH_WIDTH*PKT_W-1:0] fs2Packet_o;
    logic [FETCH_WIDTH*2-1:0]     predCounter_o;
    logic [FETCH_WIDTH-1:0]       valid_bundle_o;
    logic [$clog2(DEPTH):0]       occupancy_o;
    modport master (
        output flush_i, laneActive_i, fs1Ready_i, fs2Packet_i, predCounter_i, stall_i,
        input  stall_o, fs2Ready_o, fs2Packet_o, predCounter_o, valid_bundle_o, occupancy_o
    );
    modport slave (
        input  flush_i, laneActive_i, fs1Ready_i, fs2Packet_i, predCounter_i, stall_i,
        output stall_o, fs2Ready_o, fs2Packet_o, predCounter_o, valid_bundle_o, occupancy_o
    );
endinterface

// File: rtl/fetch2_bundle_queue.sv
// fetch2_bundle_queue: circular buffer of fetch bundles between Fetch1 and Fetch2
//   clk    clock
//   reset  synchronous, active-high; clears pointers and count (storage is not cleared)
//   bus    fetch2_bundle_queue_if.slave: incoming bundle, flush, lane mask and back-pressure in;
//          head bundle, per-lane valid, stall and occupancy out
// A bundle pushed in cycle N is visible at the head in cycle N+1 (no bypass).
module fetch2_bundle_queue #(
    parameter int FETCH_WIDTH = 4,
    parameter int PKT_W       = 64,
    parameter int VALID_BIT   = 0,
    parameter int DEPTH       = 4
) (
    input logic                   clk,
    input logic                   reset,
    fetch2_bundle_queue_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int BW    = FETCH_WIDTH * PKT_W;
    localparam int CW    = FETCH_WIDTH * 2;

    logic [BW-1:0]    pkt_mem [DEPTH];
    logic [CW-1:0]    pc_mem  [DEPTH];
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push, pop, full, nonempty;

    // Both flags come from the registered count only, so stall_o has no input-to-output path.
    assign full     = count_q == CNT_W'(DEPTH);
    assign nonempty = count_q != '0;

    // A held bundle upstream (stall_o=1) is never rewritten because push is gated by full.
    always_comb begin
        push    = bus.fs1Ready_i & ~full & ~bus.flush_i;
        pop     = nonempty & ~bus.stall_i & ~bus.flush_i;
        head_d  = bus.flush_i ? '0 : head_q + PTR_W'(pop);
        tail_d  = bus.flush_i ? '0 : tail_q + PTR_W'(push);
        count_d = bus.flush_i ? '0 : count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Packet and counter of every lane live in the same entry, so they stay aligned.
    always_ff @(posedge clk) begin
        if (push) begin
            pkt_mem[tail_q] <= bus.fs2Packet_i;
            pc_mem[tail_q]  <= bus.predCounter_i;
        end
    end

    assign bus.stall_o       = full;
    assign bus.fs2Ready_o    = nonempty;
    assign bus.occupancy_o   = count_q;
    assign bus.fs2Packet_o   = nonempty ? pkt_mem[head_q] : '0;
    assign bus.predCounter_o = nonempty ? pc_mem[head_q] : '0;

    // Lane mask only qualifies the reported valid; stored data is untouched.
    for (genvar l = 0; l < FETCH_WIDTH; l++) begin : g_lane
        assign bus.valid_bundle_o[l] = bus.fs2Packet_o[l*PKT_W+VALID_BIT] & bus.laneActive_i[l];
    end
endmodule

// File: tb/tb_fetch2_bundle_queue.sv
// tb_fetch2_bundle_queue: scoreboard bench for fetch2_bundle_queue
module tb_fetch2_bundle_queue;
    typedef struct packed {
        logic [255:0] p;
        logic [7:0]   c;
    } ent_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    bit   chk_en = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   exp_cnt = 0;
    ent_t sb[$];

    fetch2_bundle_queue_if bus ();

    fetch2_bundle_queue dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [255:0] mkp(int id, logic [3:0] vm);
        logic [255:0] p;
        for (int l = 0; l < 4; l++) p[l*64 +: 64] = {24'hA5A5A5, 8'(id), 8'(l), 23'h0, vm[l]};
        return p;
    endfunction

    function automatic logic [7:0] mkc(int id);
        return 8'(id * 37 + 5);
    endfunction

    task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Driver-side model: at each active edge record what the queue must have accepted.
    task automatic cyc();
        bit p, q;
        @(posedge clk);
        p = bus.fs1Ready_i && exp_cnt != 4 && !bus.flush_i;
        q = exp_cnt != 0 && !bus.stall_i && !bus.flush_i;
        if (bus.flush_i) begin
            sb.delete();
            exp_cnt = 0;
        end else begin
            if (p) sb.push_back('{p: bus.fs2Packet_i, c: bus.predCounter_i});
            exp_cnt = exp_cnt + int'(p) - int'(q);
        end
        #1;
    endtask

    task automatic send(int id, logic [3:0] vm, logic st, logic fl);
        bus.fs1Ready_i    = 1'b1;
        bus.fs2Packet_i   = mkp(id, vm);
        bus.predCounter_i = mkc(id);
        bus.stall_i       = st;
        bus.flush_i       = fl;
        cyc();
    endtask

    task automatic idle(logic st, int n);
        bus.fs1Ready_i = 1'b0;
        bus.flush_i    = 1'b0;
        bus.stall_i    = st;
        repeat (n) cyc();
    endtask

    // Monitor: compares status every cycle and the head bundle whenever one is presented.
    always @(negedge clk) begin
        if (chk_en) begin
            logic [3:0] ev;
            chk("occupancy", 256'(bus.occupancy_o), 256'(exp_cnt));
            chk("stall_o", 256'(bus.stall_o), 256'(exp_cnt == 4));
            chk("fs2Ready_o", 256'(bus.fs2Ready_o), 256'(exp_cnt != 0));
            if (exp_cnt == 0) begin
                chk("empty_packet", bus.fs2Packet_o, 256'(0));
                chk("empty_counter", 256'(bus.predCounter_o), 256'(0));
                chk("empty_valid", 256'(bus.valid_bundle_o), 256'(0));
            end else if (sb.size() == 0) begin
                chk("scoreboard_nonempty", 256'(0), 256'(1));
            end else begin
                for (int l = 0; l < 4; l++) ev[l] = sb[0].p[l*64] & bus.laneActive_i[l];
                chk("head_packet", bus.fs2Packet_o, sb[0].p);
                chk("head_counter", 256'(bus.predCounter_o), 256'(sb[0].c));
                chk("valid_bundle", 256'(bus.valid_bundle_o), 256'(ev));
                if (!bus.stall_i && !bus.flush_i) void'(sb.pop_front());
            end
        end
    end

    initial begin
        bus.flush_i       = 1'b0;
        bus.laneActive_i  = 4'b1111;
        bus.fs1Ready_i    = 1'b0;
        bus.fs2Packet_i   = '0;
        bus.predCounter_i = '0;
        bus.stall_i       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset  = 1'b0;
        chk_en = 1'b1;
        idle(0, 1);
        send(1, 4'b1111, 0, 0);
        idle(0, 2);
        for (int i = 2; i <= 5; i++) send(i, 4'b1111, 1, 0);
        repeat (3) send(6, 4'b0101, 1, 0);
        send(6, 4'b0101, 0, 0);
        send(6, 4'b0101, 1, 0);
        idle(0, 6);
        send(7, 4'b1001, 1, 0);
        send(8, 4'b0110, 1, 0);
        for (int i = 9; i <= 18; i++) send(i, 4'(i), 0, 0);
        idle(0, 4);
        for (int i = 20; i <= 22; i++) send(i, 4'b1111, 1, 0);
        send(23, 4'b1111, 1, 1);
        idle(0, 3);
        bus.laneActive_i = 4'b0011;
        send(24, 4'b1111, 1, 0);
        idle(1, 1);
        bus.laneActive_i = 4'b1111;
        send(25, 4'b1010, 1, 0);
        bus.laneActive_i = 4'b0011;
        idle(0, 4);
        bus.laneActive_i = 4'b1111;
        idle(0, 1);
        chk("scoreboard_drained", 256'(sb.size()), 256'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
